// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data-side memory and the datapath controller:
// access-size codes and the memory unit's controller state encoding.
package data_mem_unit_pkg;

  // Access size codes on mem_size; the reserved code behaves as a word access.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned DATA_W = 32;

  // Controller state: sweeping the array to zero, or serving loads/stores.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_unit_lane_merge.sv
// lane_merge: merges store data into the addressed lanes of the existing word
// and flags stores whose address is not aligned to the access size.
//   old_word_i    current contents of the addressed word
//   wdata_i       store data (half/byte taken from the low bits)
//   size_i        access size code
//   lane_i        addr[1:0] of the store
//   merged_o      word after the lane merge
//   misaligned_o  1 when the store must be dropped
module lane_merge
  import data_mem_unit_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o,
  output logic        misaligned_o
);

  always_comb begin
    merged_o     = old_word_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_HALF: begin
        misaligned_o = lane_i[0];
        if (lane_i[1]) merged_o = {wdata_i[15:0], old_word_i[15:0]};
        else           merged_o = {old_word_i[31:16], wdata_i[15:0]};
      end
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merged_o = {old_word_i[31:8], wdata_i[7:0]};
          2'd1:    merged_o = {old_word_i[31:16], wdata_i[7:0], old_word_i[7:0]};
          2'd2:    merged_o = {old_word_i[31:24], wdata_i[7:0], old_word_i[15:0]};
          default: merged_o = {wdata_i[7:0], old_word_i[23:0]};
        endcase
      end
      default: begin
        // Word and reserved code: full-word store, lane must be zero.
        misaligned_o = (lane_i != 2'd0);
        merged_o     = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: data-side memory for the single-cycle datapath. Accepts
// word/half/byte stores and sign/zero-extending loads, logs accepted stores in
// simulation, and zero-sweeps the whole array one word per cycle after reset.
//   clk        rising-edge clock
//   reset      synchronous active-high; (re)starts the clear sweep
//   mem_write  store request
//   mem_size   00 word, 01 half, 10 byte, 11 treated as word
//   ld_sign    1 sign-extends half/byte loads, 0 zero-extends
//   addr       byte address; word index addr[AW+1:2], lane addr[1:0]
//   wdata      store data
//   pc         PC of the storing instruction (store log only)
//   rdata      extended load data, combinational, 0 while busy
//   busy       high during the clear sweep
//   align_err  one-cycle pulse after a dropped misaligned store
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        ld_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        align_err
);

  localparam int unsigned DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] LAST_PTR = {AW{1'b1}};

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic            align_err_q, align_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     word_idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic              misaligned;

  logic              mem_we_c;
  logic [AW-1:0]     mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              store_ok_c;

  // Upper address bits are ignored, so accesses wrap modulo the array size.
  assign word_idx = addr[AW+1:2];
  assign old_word = mem_q[word_idx];

  lane_merge u_lane_merge (
    .old_word_i   (old_word),
    .wdata_i      (wdata),
    .size_i       (mem_size),
    .lane_i       (addr[1:0]),
    .merged_o     (merged),
    .misaligned_o (misaligned)
  );

  // Next-state logic: sweep while clearing, accept stores once ready.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    align_err_d = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = word_idx;
    mem_wdata_c = merged;
    store_ok_c  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_ptr_q;
        mem_wdata_c = '0;
        clr_ptr_d   = clr_ptr_q + AW'(1);
        if (clr_ptr_q == LAST_PTR) state_d = ST_READY;
      end
      ST_READY: begin
        if (mem_write) begin
          if (misaligned) begin
            align_err_d = 1'b1;
          end else begin
            mem_we_c   = 1'b1;
            store_ok_c = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Control registers; reset wins over any store in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      align_err_q <= align_err_d;
    end
  end

  // Storage array: single write port shared by the sweep and the store path.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

`ifndef SYNTHESIS
  // Store trace for simulation runs.
  always_ff @(posedge clk) begin
    if (!reset && store_ok_c)
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
  end
`endif

  // Load extractor: pick the lane and extend.
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_ext;

  always_comb begin
    ld_half = addr[1] ? old_word[31:16] : old_word[15:0];
    case (addr[1:0])
      2'd0:    ld_byte = old_word[7:0];
      2'd1:    ld_byte = old_word[15:8];
      2'd2:    ld_byte = old_word[23:16];
      default: ld_byte = old_word[31:24];
    endcase
    case (mem_size)
      SZ_HALF: ld_ext = ld_sign ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
      SZ_BYTE: ld_ext = ld_sign ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      default: ld_ext = old_word;
    endcase
  end

  assign busy      = (state_q == ST_CLEAR);
  assign rdata     = busy ? '0 : ld_ext;
  assign align_err = align_err_q;

endmodule
